lane_merge_fifo: RTL and testbench

- Downstream neighbour of the 4-lane demux/recirculation stage.
- Accepts up to four 8-bit lane bytes per cycle into per-lane FIFOs and merges them round-robin onto one 8-bit stream with a valid/ready handshake.
- Generates IDLE_OUT, which the recirculation stage uses to decide between recirculating and forwarding.
- Single clock domain, clk_4f; one output byte per cycle.

---
 rtl/lane_merge_pkg.sv | 12 +
 rtl/lane_merge_fifo_lane_fifo.sv | 64 ++++++
 rtl/lane_merge_fifo.sv | 128 ++++++++++++
 tb/tb_lane_merge_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lane_merge_pkg.sv
// Shared types and default sizing for the four-lane merge FIFO.
package lane_merge_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AF_TH  = 3;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [1:0] {IDLE, SEND, STALL} arb_state_t;
endpackage

// File: rtl/lane_merge_fifo_lane_fifo.sv
// Per-lane synchronous FIFO with sticky overflow flag and registered almost-full.
module lane_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AF_TH  = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(AF_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              af_q, err_q;
    logic              full, pop_ok, push_ok, drop;

    assign full    = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop    = push_i && full && !pop_ok;
    assign head_o  = mem_q[rd_q];
    assign almost_full_o = af_q;
    assign err_o   = err_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok)
                rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            af_q    <= (count_q >= AF_CNT);
            err_q   <= err_q | drop;
        end
    end
endmodule

// File: rtl/lane_merge_fifo.sv
// Merges four lane FIFOs onto one valid/ready byte stream and flags idleness.
// LANE_MERGE_FIXED_PRIO_EN selects fixed lane-0-first priority instead of round-robin.
module lane_merge_fifo #(
    parameter int unsigned DATA_W = lane_merge_pkg::DATA_W,
    parameter int unsigned DEPTH  = lane_merge_pkg::DEPTH,
    parameter int unsigned AF_TH  = lane_merge_pkg::AF_TH
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    input  logic              valid_3,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_out,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              almost_full_2,
    output logic              almost_full_3,
    output logic [3:0]        err_overflow,
    output logic              IDLE_OUT
);
    import lane_merge_pkg::*;

    logic [DATA_W-1:0] din  [LANES];
    logic [DATA_W-1:0] head [LANES];
    logic [LANES-1:0]  push, pop, empty, af;
    arb_state_t        state_q;
    logic [DATA_W-1:0] data_q;
    lane_idx_t         lane_q, grant;
    logic              idle_q, found, load;

    assign din[0] = data_0;
    assign din[1] = data_1;
    assign din[2] = data_2;
    assign din[3] = data_3;
    assign push   = {valid_3, valid_2, valid_1, valid_0};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign pop[g] = load && found && (grant == lane_idx_t'(g));
        lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH)) u_fifo (
            .clk_i         (clk_4f),
            .reset_i       (reset),
            .push_i        (push[g]),
            .data_i        (din[g]),
            .pop_i         (pop[g]),
            .head_o        (head[g]),
            .empty_o       (empty[g]),
            .almost_full_o (af[g]),
            .err_o         (err_overflow[g])
        );
    end

    assign valid_out = (state_q != IDLE);
    assign load      = !valid_out || ready_out;

`ifdef LANE_MERGE_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found && !empty[i]) begin
                found = 1'b1;
                grant = lane_idx_t'(i);
            end
        end
    end
`else
    lane_idx_t rr_q, idx;

    // Search wraps through the 2-bit index, starting at the lane after the last grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = rr_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            idx = rr_q + lane_idx_t'(i);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset)
            rr_q <= '0;
        else if (load && found)
            rr_q <= grant + 1'b1;
    end
`endif

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            lane_q  <= '0;
            idle_q  <= 1'b0;
        end else begin
            idle_q <= (&empty) && (state_q == IDLE);
            if (load) begin
                if (found) begin
                    data_q  <= head[grant];
                    lane_q  <= grant;
                    state_q <= SEND;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                state_q <= STALL;
            end
        end
    end

    assign data_out      = data_q;
    assign lane_out      = lane_q;
    assign IDLE_OUT      = idle_q;
    assign almost_full_0 = af[0];
    assign almost_full_1 = af[1];
    assign almost_full_2 = af[2];
    assign almost_full_3 = af[3];
endmodule

// File: tb/tb_lane_merge_fifo.sv
// Directed bench for lane_merge_fifo; expectations follow LANE_MERGE_FIXED_PRIO_EN.
module tb_lane_merge_fifo;
    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic       almost_full_0, almost_full_1, almost_full_2, almost_full_3;
    logic [3:0] err_overflow;
    logic       IDLE_OUT;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_d [6];
    logic [1:0]  exp_l [6];

    lane_merge_fifo #(.DATA_W(8), .DEPTH(4), .AF_TH(3)) dut (
        .clk_4f(clk_4f), .reset(reset),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
        .lane_out(lane_out),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .almost_full_2(almost_full_2), .almost_full_3(almost_full_3),
        .err_overflow(err_overflow), .IDLE_OUT(IDLE_OUT)
    );

    always #5 clk_4f = ~clk_4f;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] l);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
        chk({tag, "_lane"}, {30'd0, lane_out}, {30'd0, l});
    endtask

    task automatic novalid();
        valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
    endtask

    task automatic do_reset();
        novalid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
`ifdef LANE_MERGE_FIXED_PRIO_EN
        exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12;
        exp_d[3] = 8'h30; exp_d[4] = 8'h31; exp_d[5] = 8'h32;
        exp_l[0] = 2'd0; exp_l[1] = 2'd0; exp_l[2] = 2'd0;
        exp_l[3] = 2'd3; exp_l[4] = 2'd3; exp_l[5] = 2'd3;
`else
        exp_d[0] = 8'h10; exp_d[1] = 8'h30; exp_d[2] = 8'h11;
        exp_d[3] = 8'h31; exp_d[4] = 8'h12; exp_d[5] = 8'h32;
        exp_l[0] = 2'd0; exp_l[1] = 2'd3; exp_l[2] = 2'd0;
        exp_l[3] = 2'd3; exp_l[4] = 2'd0; exp_l[5] = 2'd3;
`endif
        reset = 1'b1; ready_out = 1'b0; novalid();
        data_0 = '0; data_1 = '0; data_2 = '0; data_3 = '0;
        tick(); tick();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_lane", {30'd0, lane_out}, 32'd0);
        chk("rst_af", {28'd0, almost_full_3, almost_full_2, almost_full_1, almost_full_0}, 32'd0);
        chk("rst_err", {28'd0, err_overflow}, 32'd0);
        chk("rst_idle", {31'd0, IDLE_OUT}, 32'd0);
        reset = 1'b0;
        tick(); tick();
        chk("rel_idle", {31'd0, IDLE_OUT}, 32'd1);

        // all four lanes in one edge, drained in lane order
        ready_out = 1'b1;
        data_0 = 8'hff; data_1 = 8'hee; data_2 = 8'hdd; data_3 = 8'hcc;
        valid_0 = 1'b1; valid_1 = 1'b1; valid_2 = 1'b1; valid_3 = 1'b1;
        tick(); novalid();
        chk("t1_nobypass", {31'd0, valid_out}, 32'd0);
        tick(); chk_out("t1_b0", 8'hff, 2'd0);
        tick(); chk_out("t1_b1", 8'hee, 2'd1);
        tick(); chk_out("t1_b2", 8'hdd, 2'd2);
        tick(); chk_out("t1_b3", 8'hcc, 2'd3);
        chk("t1_busy", {31'd0, IDLE_OUT}, 32'd0);
        tick();
        chk("t1_drained", {31'd0, valid_out}, 32'd0);
        chk("t1_hold_data", {24'd0, data_out}, 32'hcc);
        chk("t1_hold_lane", {30'd0, lane_out}, 32'd3);
        chk("t1_idle_lag", {31'd0, IDLE_OUT}, 32'd0);
        tick();
        chk("t1_idle", {31'd0, IDLE_OUT}, 32'd1);

        // stall holds the output register
        do_reset(); ready_out = 1'b0;
        valid_1 = 1'b1; data_1 = 8'h77; tick();
        data_1 = 8'h78; tick(); novalid();
        chk_out("t2_s0", 8'h77, 2'd1);
        tick(); chk_out("t2_s1", 8'h77, 2'd1);
        tick(); chk_out("t2_s2", 8'h77, 2'd1);
        ready_out = 1'b1;
        tick(); chk_out("t2_next", 8'h78, 2'd1);
        tick(); chk("t2_empty", {31'd0, valid_out}, 32'd0);

        // overflow on lane 2 behind a stalled lane-0 byte
        do_reset(); ready_out = 1'b0;
        valid_0 = 1'b1; data_0 = 8'h01; tick(); valid_0 = 1'b0;
        valid_2 = 1'b1; data_2 = 8'h20; tick();
        chk_out("t3_hold", 8'h01, 2'd0);
        data_2 = 8'h21; tick();
        data_2 = 8'h22; tick();
        chk("t3_af_pre", {31'd0, almost_full_2}, 32'd0);
        data_2 = 8'h23; tick();
        chk("t3_af", {31'd0, almost_full_2}, 32'd1);
        chk("t3_err_pre", {28'd0, err_overflow}, 32'd0);
        data_2 = 8'h24; tick(); novalid();
        chk("t3_err", {28'd0, err_overflow}, 32'h4);
        tick(); tick();
        chk("t3_err_sticky", {28'd0, err_overflow}, 32'h4);
        ready_out = 1'b1;
        tick(); chk_out("t3_d0", 8'h20, 2'd2);
        tick(); chk_out("t3_d1", 8'h21, 2'd2);
        tick(); chk_out("t3_d2", 8'h22, 2'd2);
        tick(); chk_out("t3_d3", 8'h23, 2'd2);
        tick(); chk("t3_dropped", {31'd0, valid_out}, 32'd0);
        chk("t3_err_end", {28'd0, err_overflow}, 32'h4);

        // lanes 0 and 3 both busy: arbitration order
        do_reset(); ready_out = 1'b1;
        valid_0 = 1'b1; valid_3 = 1'b1;
        data_0 = 8'h10; data_3 = 8'h30; tick();
        data_0 = 8'h11; data_3 = 8'h31; tick();
        chk_out("t4_g0", exp_d[0], exp_l[0]);
        data_0 = 8'h12; data_3 = 8'h32; tick(); novalid();
        chk_out("t4_g1", exp_d[1], exp_l[1]);
        tick(); chk_out("t4_g2", exp_d[2], exp_l[2]);
        tick(); chk_out("t4_g3", exp_d[3], exp_l[3]);
        tick(); chk_out("t4_g4", exp_d[4], exp_l[4]);
        tick(); chk_out("t4_g5", exp_d[5], exp_l[5]);

        // reset mid-stream flushes everything
        do_reset(); ready_out = 1'b0;
        data_0 = 8'h41; data_1 = 8'h42; data_2 = 8'h43; data_3 = 8'h44;
        valid_0 = 1'b1; valid_1 = 1'b1; valid_2 = 1'b1; valid_3 = 1'b1;
        tick(); novalid();
        tick(); chk_out("t5_pre", 8'h41, 2'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_valid", {31'd0, valid_out}, 32'd0);
        chk("t5_data", {24'd0, data_out}, 32'd0);
        chk("t5_idle", {31'd0, IDLE_OUT}, 32'd0);
        ready_out = 1'b1;
        tick(); tick();
        chk("t5_idle_rel", {31'd0, IDLE_OUT}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_flushed", {31'd0, valid_out}, 32'd0);
            tick();
        end

        // full lane 0 pushed and popped on the same edge
        do_reset(); ready_out = 1'b0;
        valid_1 = 1'b1; data_1 = 8'h5a; tick(); valid_1 = 1'b0;
        valid_0 = 1'b1;
        data_0 = 8'ha0; tick();
        data_0 = 8'ha1; tick();
        data_0 = 8'ha2; tick();
        data_0 = 8'ha3; tick();
        chk("t6_af", {31'd0, almost_full_0}, 32'd1);
        data_0 = 8'ha4; ready_out = 1'b1; tick(); novalid();
        chk_out("t6_p0", 8'ha0, 2'd0);
        chk("t6_err", {28'd0, err_overflow}, 32'd0);
        tick(); chk_out("t6_p1", 8'ha1, 2'd0);
        tick(); chk_out("t6_p2", 8'ha2, 2'd0);
        tick(); chk_out("t6_p3", 8'ha3, 2'd0);
        tick(); chk_out("t6_p4", 8'ha4, 2'd0);
        tick(); chk("t6_empty", {31'd0, valid_out}, 32'd0);
        chk("t6_err_end", {28'd0, err_overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
